// File: rtl/mem_pkg.sv
// Shared memory-stage types: controller state and cache/line geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR
    } state_e;

    localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
    localparam int          CACHE_AW_DEF  = 17;
    localparam int          LINE_W        = 64;

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the data cache and the SRAM controller.
interface cache_controller_if
    import mem_pkg::*;
#(
    parameter int CACHE_AW = CACHE_AW_DEF
);
    logic                mem_r_en;
    logic                mem_w_en;
    logic [31:0]         address;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                ready;
    logic [CACHE_AW-1:0] cache_address;
    logic [LINE_W-1:0]   cache_wdata;
    logic                cache_read;
    logic                cache_write;
    logic                cache_invalid;
    logic [31:0]         cache_rdata;
    logic                cache_hit;
    logic [31:0]         sram_address;
    logic [31:0]         sram_wdata;
    logic                sram_r_en;
    logic                sram_w_en;
    logic [LINE_W-1:0]   sram_rdata;
    logic                sram_ready;

    modport master (
        input  mem_r_en, mem_w_en, address, wdata,
        input  cache_rdata, cache_hit, sram_rdata, sram_ready,
        output rdata, ready, cache_address, cache_wdata,
        output cache_read, cache_write, cache_invalid,
        output sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport slave (
        output mem_r_en, mem_w_en, address, wdata,
        output cache_rdata, cache_hit, sram_rdata, sram_ready,
        input  rdata, ready, cache_address, cache_wdata,
        input  cache_read, cache_write, cache_invalid,
        input  sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/cache_controller.sv
// Cache/SRAM glue FSM: hits answered in-cycle, misses fill a line from SRAM,
// stores write through to SRAM and invalidate the cached copy.
module cache_controller
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
    parameter int          CACHE_AW  = CACHE_AW_DEF
) (
    input logic                clk,
    input logic                rst,
    cache_controller_if.master bus
);
    state_e state_q, state_d;

    logic [CACHE_AW-1:0] caddr;
    logic                word_sel;

    assign caddr    = CACHE_AW'((bus.address - ADDR_BASE) >> 2);
    assign word_sel = caddr[0];

    assign bus.cache_address = caddr;
    assign bus.cache_wdata   = bus.sram_rdata;
    assign bus.sram_address  = bus.address & ~32'h7;
    assign bus.sram_wdata    = bus.wdata;

    // Requests are gated by rst so an asserted reset never starts a miss.
    always_comb begin
        state_d           = state_q;
        bus.ready         = 1'b1;
        bus.rdata         = 32'h0;
        bus.cache_read    = 1'b0;
        bus.cache_write   = 1'b0;
        bus.cache_invalid = 1'b0;
        bus.sram_r_en     = 1'b0;
        bus.sram_w_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst && bus.mem_w_en) begin
                    bus.cache_invalid = 1'b1;
                    bus.sram_w_en     = 1'b1;
                    bus.ready         = 1'b0;
                    state_d           = WR;
                end else if (rst && bus.mem_r_en) begin
                    if (bus.cache_hit) begin
                        bus.cache_read = 1'b1;
                        bus.rdata      = bus.cache_rdata;
                    end else begin
                        bus.sram_r_en = 1'b1;
                        bus.ready     = 1'b0;
                        state_d       = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                bus.sram_r_en = 1'b1;
                bus.ready     = bus.sram_ready;
                if (bus.sram_ready) begin
                    bus.cache_write = 1'b1;
                    bus.rdata       = word_sel ? bus.sram_rdata[63:32]
                                               : bus.sram_rdata[31:0];
                    state_d         = IDLE;
                end
            end
            WR: begin
                bus.sram_w_en = 1'b1;
                bus.ready     = bus.sram_ready;
                if (bus.sram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Random transaction bench for cache_controller with a transaction-level model.
module tb_cache_controller;
    localparam int NONE = 0;
    localparam int RDB  = 1;
    localparam int WRB  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_busy = NONE;
    int   m_next = NONE;
    logic e_ready;

    cache_controller_if bus_if ();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the outstanding-transaction view of the controller.
    task automatic eval();
        logic [5:0]  es;
        logic [31:0] er;
        logic [31:0] off;
        #2;
        es     = 6'b100000;
        er     = 32'h0;
        off    = bus_if.address - 32'd1024;
        if (!rst) m_busy = NONE;
        m_next = m_busy;
        if (!rst) begin
            m_next = NONE;
        end else if (m_busy == NONE) begin
            if (bus_if.mem_w_en) begin
                es     = 6'b000101;
                m_next = WRB;
            end else if (bus_if.mem_r_en && bus_if.cache_hit) begin
                es = 6'b110000;
                er = bus_if.cache_rdata;
            end else if (bus_if.mem_r_en) begin
                es     = 6'b000010;
                m_next = RDB;
            end
        end else if (m_busy == RDB) begin
            es = 6'b000010;
            if (bus_if.sram_ready) begin
                es     = 6'b101010;
                er     = ((off / 4) % 2 == 1) ? bus_if.sram_rdata[63:32]
                                              : bus_if.sram_rdata[31:0];
                m_next = NONE;
            end
        end else begin
            es = 6'b000001;
            if (bus_if.sram_ready) begin
                es     = 6'b100001;
                m_next = NONE;
            end
        end
        e_ready = es[5];
        chk("strobes", {bus_if.ready, bus_if.cache_read, bus_if.cache_write,
                        bus_if.cache_invalid, bus_if.sram_r_en,
                        bus_if.sram_w_en}, es);
        chk("rdata", bus_if.rdata, er);
        chk("cache_addr", bus_if.cache_address, (off / 4) % (1 << 17));
        chk("sram_addr", bus_if.sram_address,
            bus_if.address - bus_if.address % 8);
        chk("sram_wdata", bus_if.sram_wdata, bus_if.wdata);
        if (es[3]) chk("fill", bus_if.cache_wdata, bus_if.sram_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        m_busy = rst ? m_next : NONE;
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.mem_r_en = 1'b0;
        bus_if.mem_w_en = 1'b0;
        bus_if.cache_hit = 1'b0;
        bus_if.sram_ready = 1'b0;
    endtask

    task automatic txn(bit r, bit w, logic [31:0] a, logic [31:0] d, bit hit,
                       logic [31:0] crd, logic [63:0] srd, int waits,
                       bit stray);
        bit done = 1'b0;
        bus_if.mem_r_en    = r;
        bus_if.mem_w_en    = w;
        bus_if.address     = a;
        bus_if.wdata       = d;
        bus_if.cache_hit   = hit;
        bus_if.cache_rdata = crd;
        bus_if.sram_rdata  = srd;
        for (int c = 0; c < 32 && !done; c++) begin
            bus_if.sram_ready = (c == 0) ? stray : (c > waits);
            eval();
            done = e_ready;
            tick();
        end
        if (!done) chk("timeout", 1'b0, 1'b1);
        idle_inputs();
    endtask

    initial begin
        bus_if.address     = 32'h444;
        bus_if.wdata       = 32'h0;
        bus_if.cache_rdata = 32'h0;
        bus_if.sram_rdata  = 64'h0;
        idle_inputs();
        bus_if.mem_r_en = 1'b1;
        #1 rst = 1'b0;
        eval();
        tick();
        eval();
        rst = 1'b1;
        bus_if.mem_r_en = 1'b0;
        tick();

        txn(1, 0, 32'h444, 0, 1, 32'h12345678, 64'h0, 0, 0);
        txn(1, 0, 32'h444, 0, 0, 32'h55555555,
            64'hBBBBBBBB_AAAAAAAA, 3, 0);
        txn(1, 0, 32'h444, 0, 1, 32'hBBBBBBBB, 64'h0, 0, 0);
        txn(0, 1, 32'h408, 32'hCAFEF00D, 0, 0, 64'h0, 2, 1);
        txn(1, 1, 32'h40C, 32'h1, 0, 0, 64'h0, 1, 0);
        txn(1, 0, 32'h40C, 0, 0, 0, 64'h11111111_22222222, 0, 1);

        // Reset lands while a miss is outstanding.
        bus_if.mem_r_en = 1'b1;
        bus_if.address  = 32'h450;
        eval();
        tick();
        eval();
        rst = 1'b0;
        eval();
        idle_inputs();
        tick();
        rst = 1'b1;
        bus_if.sram_ready = 1'b1;
        eval();
        tick();
        eval();
        tick();
        idle_inputs();

        for (int i = 0; i < 300; i++) begin
            int          k    = $urandom_range(0, 9);
            logic [31:0] a    = (32'd1024 + $urandom_range(0, 32'h7FFFF)) & ~32'h3;
            logic [63:0] srd  = {$urandom, $urandom};
            if (k < 3) txn(1, 0, a, $urandom, 1, $urandom, srd, 0, 0);
            else if (k < 6)
                txn(1, 0, a, $urandom, 0, $urandom, srd,
                    $urandom_range(0, 4), 1'($urandom));
            else if (k < 9)
                txn(0, 1, a, $urandom, 1'($urandom), $urandom, srd,
                    $urandom_range(0, 4), 1'($urandom));
            else
                txn(1, 1, a, $urandom, 1'($urandom), $urandom, srd,
                    $urandom_range(0, 3), 0);
            if ($urandom_range(0, 1) == 1) begin
                bus_if.sram_ready = 1'($urandom);
                eval();
                tick();
                idle_inputs();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Glue FSM between the MEM stage and the 2-way 17-bit-word-addressed data cache plus the off-chip SRAM controller. It issues the cache's read/write/invalid strobes and stalls the pipeline on misses and writes. On a read miss it fetches the 64-bit line from SRAM and fills the cache. On a store it writes through to SRAM and invalidates the cached copy.

## Interface
- `ADDR_BASE`, 1024: byte address where data memory starts; subtracted before mapping.
- `CACHE_AW`, 17: cache word-address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `mem_r_en` in 1: CPU load request.
- `mem_w_en` in 1: CPU store request.
- `address` in 32: CPU byte address.
- `wdata` in 32: CPU store data.
- `rdata` out 32: load data to CPU.
- `ready` out 1: 0 = freeze pipeline.
- `cache_address` out 17: `(address-ADDR_BASE)[18:2]`.
- `cache_wdata` out 64: line fill data.
- `cache_read` out 1: cache read strobe.
- `cache_write` out 1: cache fill strobe.
- `cache_invalid` out 1: cache invalidate strobe.
- `cache_rdata` in 32: cache hit data.
- `cache_hit` in 1: cache hit.
- `sram_address` out 32: line-aligned byte address, `address & ~32'h7`.
- `sram_wdata` out 32: store data, equal to `wdata`.
- `sram_r_en` out 1: SRAM line read request.
- `sram_w_en` out 1: SRAM word write request.
- `sram_rdata` in 64: `{word at +4, word at +0}`.
- `sram_ready` in 1: SRAM transaction complete.

## Operation
- State is one register, with states IDLE, RD_MISS and WR.
- Outputs are combinational from state plus inputs.
- **Address mapping:** `off = address - ADDR_BASE` (32-bit). `cache_address = off[18:2]`. `word_sel = off[2]`.
- **IDLE with no request:** `ready=1`; all strobes 0.
- **IDLE, store (`mem_w_en=1`):**
  - `cache_invalid=1` this cycle only.
  - `sram_w_en=1`, `ready=0`; next state WR.
  - Store has priority over a simultaneous load.
- **IDLE, load with `cache_hit=1`:** `cache_read=1`, `rdata=cache_rdata`, `ready=1`; stay IDLE.
- **IDLE, load with `cache_hit=0`:** `sram_r_en=1`, `ready=0`; next state RD_MISS.
- **RD_MISS:**
  - `sram_r_en` is held at 1.
  - When `sram_ready=1`:
    - `cache_write=1` and `cache_wdata=sram_rdata`.
    - `rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0]`.
    - `ready=1`; next state IDLE.
  - Otherwise `ready=0`.
- **WR:**
  - `sram_w_en` is held at 1; `cache_invalid=0`.
  - On `sram_ready`: `ready=1`; next state IDLE. Otherwise `ready=0`.
- **CPU contract:** `address`, `wdata` and the enables are held stable while `ready=0`. The controller does not latch them.
- **Unused values:** `rdata` is 0 when no valid data is presented.

## Timing
- **Reset:**
  - State goes to IDLE immediately.
  - `ready=1` when no request is present; all strobes 0; `rdata=0`.
  - Reset during RD_MISS or WR abandons the transaction: strobes drop asynchronously and no cache fill occurs.
- **Latency:**
  - Hit: 0 cycles, same-cycle `ready`.
  - Miss or store: `ready` rises in the cycle `sram_ready` is sampled high, N+1 cycles after the request when SRAM takes N wait cycles.
- **Back-to-back requests:** a request present in the cycle after returning to IDLE is evaluated fresh, so a re-issued load to the just-filled line hits.
- **Stray `sram_ready`:** ignored in IDLE.
- **`sram_ready` in the first miss/store cycle:** cannot complete the transaction, because completion is evaluated only in RD_MISS or WR.
- **`cache_write` and `cache_invalid`:** never asserted in the same cycle.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, RD_MISS, WR};
  - `ADDR_BASE` default;
  - `CACHE_AW` and line width 64.
- Single module, no sub-module. Address mapping is two assigns.
- The `Cache` and the SRAM controller are instantiated beside it in the memory-stage wrapper.

## Test plan
- **Reset:** `rst=0` with `mem_r_en=1` → `ready=1`, `sram_r_en=0`. Release → IDLE.
- **Read hit:** `address=0x444`, `cache_hit=1`, `cache_rdata=0x12345678` → same cycle `cache_address=0x11`, `cache_read=1`, `rdata=0x12345678`, `ready=1`.
- **Read miss:**
  - `address=0x444`, `cache_hit=0` → `sram_r_en=1`, `sram_address=0x440`, `ready=0`.
  - SRAM ready after 3 cycles with `64'hBBBBBBBB_AAAAAAAA` → `cache_write=1` one cycle, `rdata=0xBBBBBBBB`, `ready=1`. Next cycle IDLE.
- **Store:** `address=0x408`, `wdata=0xCAFEF00D` → cycle 0 `cache_invalid=1`, `sram_w_en=1`. Cycles 1..k `cache_invalid=0`, `ready=0`. `ready=1` on `sram_ready`. No `cache_write` at any point.
- **Simultaneous load and store:** both enables high → WR path taken; `sram_r_en` stays 0.
- **Reset mid-miss:** `rst` low during RD_MISS → strobes 0 immediately. A later `sram_ready=1` in IDLE produces no `cache_write`.
